// File: rtl/cpu_reset_ctrl_pkg.sv
// Shared definitions for the CPU reset/run/watchdog sequencer.
// STATE_W and the state enum are also used by the top-level LED/debug mux,
// so the encodings below are visible on the board and must stay fixed.
package cpu_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RUN       = 3'd2,
    ST_HALTED    = 3'd3,
    ST_WDT_RST   = 3'd4
  } cpu_state_e;

endpackage

// File: rtl/cpu_reset_ctrl_if.sv
// Bus between the PLL/CPU glue and the reset sequencer.
//   pll_locked  : PLL lock indicator, asynchronous to clk
//   wdt_kick    : single-cycle watchdog restart pulse from the CPU
//   wdt_clear   : clears the sticky wdt_fired flag
//   halt_req    : debug freeze request (level)
//   halt_ack    : high while the CPU is frozen
//   cpu_rst     : CPU reset
//   cpu_en      : CPU clock enable, 1 = execute
//   wdt_fired   : sticky watchdog-reset indicator
//   state       : current sequencer state for LEDs/debug
// master = the side driving requests (board glue / bench), slave = sequencer.
interface cpu_reset_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic               pll_locked;
  logic               wdt_kick;
  logic               wdt_clear;
  logic               halt_req;
  logic               halt_ack;
  logic               cpu_rst;
  logic               cpu_en;
  logic               wdt_fired;
  logic [STATE_W-1:0] state;

  modport master (
    output pll_locked, wdt_kick, wdt_clear, halt_req,
    input  halt_ack, cpu_rst, cpu_en, wdt_fired, state
  );

  modport slave (
    input  pll_locked, wdt_kick, wdt_clear, halt_req,
    output halt_ack, cpu_rst, cpu_en, wdt_fired, state
  );

endinterface

// File: rtl/cpu_reset_ctrl_sync_ff.sv
// Multi-stage synchronizer for a single asynchronous bit.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears every stage to 0
//   i_d  : asynchronous input
//   o_q  : synchronized output, STAGES clock edges behind i_d
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input through the flop chain; only the last stage is
  // considered safe to use in clk-domain decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/cpu_reset_ctrl.sv
// Reset, run and watchdog sequencer for the Boneless CPU on tinyBX.
// Holds the CPU in reset until the PLL lock is stable, releases it after
// HOLD_CYCLES cycles, supports a debug halt through the clock enable and
// re-resets the CPU when software stops kicking the watchdog.
//   clk  : 48 MHz PLL clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of cpu_reset_ctrl_if (lock, kick, clear, halt
//          request in; halt_ack, cpu_rst, cpu_en, wdt_fired, state out)
module cpu_reset_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 32,
  parameter int WDT_WIDTH   = 20,
  parameter int WDT_ENABLE  = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  cpu_reset_ctrl_if.slave bus
);

  localparam int                   HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WDT_WIDTH-1:0] WDT_LAST  = '1;

  cpu_state_e           r_state;
  cpu_state_e           w_stateNext;
  logic [HOLD_W-1:0]    r_holdCnt;
  logic [HOLD_W-1:0]    w_holdNext;
  logic [WDT_WIDTH-1:0] r_wdtCnt;
  logic [WDT_WIDTH-1:0] w_wdtNext;
  logic                 r_wdtFired;
  logic                 w_firedNext;
  logic                 w_lockedS;
  logic                 w_wdtTrip;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_lockSync (
    .clk(clk),
    .rst(rst),
    .i_d(bus.pll_locked),
    .o_q(w_lockedS)
  );

  // A trip needs the counter at terminal count and no kick in the same
  // cycle, so a kick landing exactly on the last cycle still saves the CPU.
  assign w_wdtTrip = (WDT_ENABLE != 0) && (r_wdtCnt == WDT_LAST) && !bus.wdt_kick;

  // State, counters and the sticky flag all live here so every output is
  // decoded from flops only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WAIT_LOCK;
      r_holdCnt  <= '0;
      r_wdtCnt   <= '0;
      r_wdtFired <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_holdCnt  <= w_holdNext;
      r_wdtCnt   <= w_wdtNext;
      r_wdtFired <= w_firedNext;
    end
  end

  // Next-state logic. Lock loss wins over a watchdog trip, which wins over
  // a halt request. Halt is only honoured from RUN, so the CPU always gets
  // at least one executing cycle after reset release. The watchdog only
  // moves in RUN and is frozen in HALTED, so a debug session cannot trip it.
  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_holdCnt;
    w_wdtNext   = r_wdtCnt;
    w_firedNext = r_wdtFired & ~bus.wdt_clear;

    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lockedS) begin
          w_stateNext = ST_HOLD;
          w_holdNext  = '0;
        end
      end

      ST_HOLD: begin
        if (!w_lockedS) begin
          w_stateNext = ST_WAIT_LOCK;
          w_holdNext  = '0;
        end else if (r_holdCnt == HOLD_LAST) begin
          w_stateNext = ST_RUN;
          w_wdtNext   = '0;
        end else begin
          w_holdNext = r_holdCnt + HOLD_W'(1);
        end
      end

      ST_RUN: begin
        if (WDT_ENABLE == 0 || bus.wdt_kick || w_wdtTrip) begin
          w_wdtNext = '0;
        end else begin
          w_wdtNext = r_wdtCnt + WDT_WIDTH'(1);
        end
        if (!w_lockedS) begin
          w_stateNext = ST_WAIT_LOCK;
        end else if (w_wdtTrip) begin
          w_stateNext = ST_WDT_RST;
          w_firedNext = 1'b1;
        end else if (bus.halt_req) begin
          w_stateNext = ST_HALTED;
        end
      end

      ST_HALTED: begin
        if (!w_lockedS) begin
          w_stateNext = ST_WAIT_LOCK;
        end else if (!bus.halt_req) begin
          w_stateNext = ST_RUN;
        end
      end

      ST_WDT_RST: begin
        if (!w_lockedS) begin
          w_stateNext = ST_WAIT_LOCK;
        end else begin
          w_stateNext = ST_HOLD;
          w_holdNext  = '0;
        end
      end

      default: begin
        w_stateNext = ST_WAIT_LOCK;
        w_holdNext  = '0;
      end
    endcase
  end

  assign bus.cpu_rst   = (r_state == ST_WAIT_LOCK) || (r_state == ST_HOLD) ||
                         (r_state == ST_WDT_RST);
  assign bus.cpu_en    = (r_state == ST_RUN);
  assign bus.halt_ack  = (r_state == ST_HALTED);
  assign bus.wdt_fired = r_wdtFired;
  assign bus.state     = r_state;

endmodule

// File: doc/cpu_reset_ctrl.md
Name: cpu_reset_ctrl

Overview:
Reset, run and watchdog sequencer for the Boneless CPU core on the tinyBX board.
- Replaces the ad-hoc reset counter in the top level.
- Holds the CPU in reset until the PLL is locked and stable, then releases it.
- Supports a debug halt handshake via a clock enable.
- Re-resets the CPU if software stops kicking a watchdog.
- Sits between the PLL and the CPU's clk/rst inputs, clocked by the 48 MHz PLL output.

Parameters:
HOLD_CYCLES, 32, cycles cpu_rst stays asserted after lock (or after a watchdog trip) before release; must be >= 2.
WDT_WIDTH, 20, watchdog counter width; timeout occurs when the counter reaches 2^WDT_WIDTH-1.
WDT_ENABLE, 1, 0 disables the watchdog (counter held at 0, never trips).
SYNC_STAGES, 2, flip-flop stages on the asynchronous pll_locked input; must be >= 2.

Ports:
clk  in  1  48 MHz PLL clock.
rst  in  1  asynchronous, active-high reset.
pll_locked  in  1  PLL lock indicator, asynchronous to clk.
wdt_kick  in  1  single-cycle pulse from a CPU output pin write; restarts the watchdog.
wdt_clear  in  1  clears the sticky wdt_fired flag.
halt_req  in  1  level; debug request to freeze the CPU.
halt_ack  out  1  high while the CPU is frozen.
cpu_rst  out  1  to the CPU rst input.
cpu_en  out  1  CPU clock enable; 1 = execute.
wdt_fired  out  1  sticky; set when a watchdog reset occurred.
state  out  3  current state encoding, for LEDs/debug.

Behaviour:
Outputs and reset:
- All outputs are registered and decoded from the state register (Moore).
- On rst: state=WAIT_LOCK, cpu_rst=1, cpu_en=0, halt_ack=0, wdt_fired=0, hold counter=0, watchdog counter=0.
- locked_s = pll_locked after SYNC_STAGES flops; all decisions use locked_s only.

States (encoding: WAIT_LOCK=0, HOLD=1, RUN=2, HALTED=3, WDT_RST=4):
- WAIT_LOCK: cpu_rst=1, cpu_en=0. If locked_s=1, go to HOLD and clear the hold counter.
- HOLD: cpu_rst=1, cpu_en=0. The hold counter increments each cycle. When the count reaches HOLD_CYCLES-1, go to RUN. cpu_rst is therefore high for exactly HOLD_CYCLES cycles in HOLD.
- RUN: cpu_rst=0, cpu_en=1. The watchdog counter increments each cycle; wdt_kick=1 loads it to 0 instead.
  - If the counter equals 2^WDT_WIDTH-1 with no kick that cycle and WDT_ENABLE=1: go to WDT_RST and set wdt_fired.
  - Else if halt_req=1: go to HALTED.
- HALTED: cpu_rst=0, cpu_en=0, halt_ack=1. The watchdog counter is frozen and kicks are ignored. When halt_req=0, go to RUN next cycle.
- WDT_RST: cpu_rst=1, cpu_en=0 for one cycle, then go to HOLD with the hold counter cleared. Total cpu_rst high time per trip is HOLD_CYCLES+1 cycles.

Priorities and boundary rules:
- Priority in every state: locked_s=0 beats the watchdog trip, which beats halt_req. locked_s=0 in any state other than WAIT_LOCK forces WAIT_LOCK next cycle; in HOLD it also clears the hold counter.
- The watchdog counter clears on every entry to RUN from HOLD. It is preserved across HALTED and resumes counting on return to RUN.
- wdt_kick on the terminal-count cycle wins: no trip occurs.
- wdt_fired: set has priority over wdt_clear in the same cycle. Cleared only by wdt_clear or rst; it survives lock loss.
- halt_req in WAIT_LOCK, HOLD or WDT_RST is ignored until RUN is reached. The CPU always executes at least one cycle after reset release.
- rst mid-operation asynchronously returns everything to reset values. The synchronizer flops are also reset to 0.
- Counter widths: hold counter is $clog2(HOLD_CYCLES) bits; watchdog counter is WDT_WIDTH bits. No wrap is possible because terminal counts force a state exit.

Decomposition:
- Shared package cpu_ctrl_pkg: the state enum (3-bit, encodings above) and the localparam STATE_W=3, reused by the top-level LED/debug mux.
- One sub-module: sync_ff (SYNC_STAGES-deep synchronizer with asynchronous reset to 0), reused later for UART RX.
- The FSM, hold counter and watchdog live in cpu_reset_ctrl.

Test Plan:
Bench parameters: HOLD_CYCLES=4, WDT_WIDTH=4, SYNC_STAGES=2.
- Power-up: rst pulse, pll_locked=1 at cycle 10. Required: cpu_rst=1 through the cycle locked_s enters HOLD plus 4 HOLD cycles, then cpu_rst=0 and cpu_en=1. state sequence 0,1,1,1,1,2.
- Watchdog trip: RUN with no kicks. Required: after 15 RUN cycles state=4, then HOLD 4 cycles, then RUN; wdt_fired=1 and stays 1; cpu_rst high for 5 cycles.
- Kick boundary: kick exactly on the 15th RUN cycle. Required: no trip, counter restarts at 0, wdt_fired remains 0. Also pulse wdt_clear in the trip cycle; required: wdt_fired=1.
- Halt: halt_req=1 for 20 cycles during RUN after 8 cycles of counting. Required: halt_ack=1 and cpu_en=0 while halted, no trip during the halt, trip 7 RUN cycles after release.
- Lock loss: drop pll_locked in HALTED and in HOLD. Required: state=0 two to three cycles later, cpu_rst=1, halt_ack=0. Relock gives the full 4-cycle HOLD again.
- Async reset mid-RUN: assert rst between clock edges. Required: cpu_rst=1 and wdt_fired=0 immediately, without waiting for a clock edge.
